// File: rtl/stepper_pkg.sv
// Shared half-step phase table for the 4-wire stepper interface, pin order {A,B,C,D} = JA1..JA4.
// The driver side uses the same constants.
package stepper_pkg;

    localparam int unsigned PHASE_W = 4;
    localparam int unsigned IDX_W   = 3;

    localparam logic [PHASE_W-1:0] PHASE_IDLE = 4'b0000;
    localparam logic [PHASE_W-1:0] PHASE_0    = 4'b0100;
    localparam logic [PHASE_W-1:0] PHASE_1    = 4'b0101;
    localparam logic [PHASE_W-1:0] PHASE_2    = 4'b0001;
    localparam logic [PHASE_W-1:0] PHASE_3    = 4'b1001;
    localparam logic [PHASE_W-1:0] PHASE_4    = 4'b1000;
    localparam logic [PHASE_W-1:0] PHASE_5    = 4'b1010;
    localparam logic [PHASE_W-1:0] PHASE_6    = 4'b0010;
    localparam logic [PHASE_W-1:0] PHASE_7    = 4'b0110;

    typedef enum logic {
        DEC_UNLOCKED = 1'b0,
        DEC_LOCKED   = 1'b1
    } dec_state_e;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } phase_lookup_t;

    // Reverse table lookup: pattern -> half-step index, valid only for the 8 table entries.
    function automatic phase_lookup_t phase_lookup(input logic [PHASE_W-1:0] pattern);
        phase_lookup_t res;
        res.valid = 1'b1;
        res.idx   = 3'd0;
        case (pattern)
            PHASE_0: res.idx = 3'd0;
            PHASE_1: res.idx = 3'd1;
            PHASE_2: res.idx = 3'd2;
            PHASE_3: res.idx = 3'd3;
            PHASE_4: res.idx = 3'd4;
            PHASE_5: res.idx = 3'd5;
            PHASE_6: res.idx = 3'd6;
            PHASE_7: res.idx = 3'd7;
            default: res.valid = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/phase_sync_filter.sv
// Two-flop synchronizer plus stability filter: a synced pattern is accepted once after holding
// GLITCH_CYCLES consecutive clocks, and never twice in a row.
module phase_sync_filter #(
    parameter int unsigned GLITCH_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] phase_i,
    output logic [3:0] pattern_o,
    output logic       accept_o
);
    import stepper_pkg::*;

    localparam int unsigned CNT_W = (GLITCH_CYCLES > 1) ? $clog2(GLITCH_CYCLES) : 1;

    logic [PHASE_W-1:0] sync1_q, sync2_q;
    logic [PHASE_W-1:0] cand_q, cand_d;
    logic [PHASE_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               accept_q, accept_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= PHASE_IDLE;
            sync2_q  <= PHASE_IDLE;
            cand_q   <= PHASE_IDLE;
            acc_q    <= PHASE_IDLE;
            cnt_q    <= '0;
            accept_q <= 1'b0;
        end else begin
            sync1_q  <= phase_i;
            sync2_q  <= sync1_q;
            cand_q   <= cand_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            accept_q <= accept_d;
        end
    end

    // cnt_q holds the number of clocks the candidate has been stable; comparing against the last
    // accepted pattern suppresses re-acceptance after a glitch returns to the held value.
    always_comb begin
        cand_d   = cand_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        accept_d = 1'b0;
        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = CNT_W'(1);
            if ((GLITCH_CYCLES <= 1) && (sync2_q != acc_q)) begin
                accept_d = 1'b1;
                acc_d    = sync2_q;
            end
        end else if (cand_q != acc_q) begin
            if (cnt_q == CNT_W'(GLITCH_CYCLES - 1)) begin
                accept_d = 1'b1;
                acc_d    = cand_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign pattern_o = acc_q;
    assign accept_o  = accept_q;

endmodule

// File: rtl/stepper_phase_decoder.sv
// Half-step stepper phase decoder: step/direction/position tracking with sticky error flags.
// Optional step-period measurement enabled by macro STEPPER_DEC_RATE_EN.
module stepper_phase_decoder #(
    parameter int unsigned GLITCH_CYCLES = 16,
    parameter int unsigned POS_W         = 32,
    parameter int unsigned PER_W         = 24
) (
    input  logic             CLK50MHZ,
    input  logic             RESETN,
    input  logic [3:0]       phase_in,
    input  logic             pos_clr,
    input  logic             err_clr,
    output logic             step_pulse,
    output logic             dir,
    output logic             locked,
    output logic [POS_W-1:0] position,
    output logic             err_illegal,
    output logic             err_skip,
    output logic [PER_W-1:0] period,
    output logic             period_valid
);
    import stepper_pkg::*;

    logic [PHASE_W-1:0] pattern;
    logic               accept;

    phase_sync_filter #(
        .GLITCH_CYCLES (GLITCH_CYCLES)
    ) u_filter (
        .clk       (CLK50MHZ),
        .rst_n     (RESETN),
        .phase_i   (phase_in),
        .pattern_o (pattern),
        .accept_o  (accept)
    );

    dec_state_e       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             step_q, step_d;
    logic             dir_q, dir_d;
    logic             ill_q, ill_d;
    logic             skip_q, skip_d;
    phase_lookup_t    lk;
    logic [IDX_W-1:0] delta;

    always_ff @(posedge CLK50MHZ or negedge RESETN) begin
        if (!RESETN) begin
            state_q <= DEC_UNLOCKED;
            idx_q   <= '0;
            pos_q   <= '0;
            step_q  <= 1'b0;
            dir_q   <= 1'b0;
            ill_q   <= 1'b0;
            skip_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pos_q   <= pos_d;
            step_q  <= step_d;
            dir_q   <= dir_d;
            ill_q   <= ill_d;
            skip_q  <= skip_d;
        end
    end

    // Decode one accepted pattern; new errors override err_clr, pos_clr overrides a step.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pos_d   = pos_q;
        step_d  = 1'b0;
        dir_d   = dir_q;
        ill_d   = ill_q & ~err_clr;
        skip_d  = skip_q & ~err_clr;
        lk      = phase_lookup(pattern);
        delta   = lk.idx - idx_q;
        if (accept) begin
            if (pattern == PHASE_IDLE) begin
                state_d = DEC_UNLOCKED;
            end else if (!lk.valid) begin
                ill_d   = 1'b1;
                state_d = DEC_UNLOCKED;
            end else if (state_q == DEC_UNLOCKED) begin
                state_d = DEC_LOCKED;
                idx_d   = lk.idx;
            end else begin
                idx_d = lk.idx;
                if (delta == 3'd1) begin
                    step_d = 1'b1;
                    dir_d  = 1'b0;
                    pos_d  = pos_q + POS_W'(1);
                end else if (delta == 3'd7) begin
                    step_d = 1'b1;
                    dir_d  = 1'b1;
                    pos_d  = pos_q - POS_W'(1);
                end else begin
                    skip_d = 1'b1;
                end
            end
        end
        if (pos_clr) begin
            pos_d = '0;
        end
    end

    assign step_pulse  = step_q;
    assign dir         = dir_q;
    assign locked      = (state_q == DEC_LOCKED);
    assign position    = pos_q;
    assign err_illegal = ill_q;
    assign err_skip    = skip_q;

`ifdef STEPPER_DEC_RATE_EN
    logic [PER_W-1:0] cyc_q, cyc_d;
    logic [PER_W-1:0] per_q, per_d;
    logic             pv_q, pv_d;
    logic             seen_q, seen_d;

    always_ff @(posedge CLK50MHZ or negedge RESETN) begin
        if (!RESETN) begin
            cyc_q  <= '0;
            per_q  <= '0;
            pv_q   <= 1'b0;
            seen_q <= 1'b0;
        end else begin
            cyc_q  <= cyc_d;
            per_q  <= per_d;
            pv_q   <= pv_d;
            seen_q <= seen_d;
        end
    end

    // First step after lock only starts the interval; the second yields a real period.
    always_comb begin
        cyc_d  = (cyc_q == {PER_W{1'b1}}) ? cyc_q : cyc_q + PER_W'(1);
        per_d  = per_q;
        pv_d   = pv_q;
        seen_d = seen_q;
        if (step_d) begin
            per_d  = cyc_q;
            cyc_d  = PER_W'(1);
            seen_d = 1'b1;
            if (seen_q) begin
                pv_d = 1'b1;
            end
        end
        if (state_d != DEC_LOCKED) begin
            pv_d   = 1'b0;
            seen_d = 1'b0;
        end
    end

    assign period       = per_q;
    assign period_valid = pv_q;
`else
    assign period       = '0;
    assign period_valid = 1'b0;
`endif

endmodule

// File: tb/tb_stepper_phase_decoder.sv
// Directed self-checking bench for stepper_phase_decoder (default parameters, GLITCH_CYCLES = 16).
module tb_stepper_phase_decoder;

    localparam int G = 16;
    localparam int LAT = 3 + G;

    logic        clk;
    logic        rst_n;
    logic [3:0]  phase_in;
    logic        pos_clr;
    logic        err_clr;
    logic        step_pulse;
    logic        dir;
    logic        locked;
    logic [31:0] position;
    logic        err_illegal;
    logic        err_skip;
    logic [23:0] period;
    logic        period_valid;

    int tests_run = 0;
    int tests_failed = 0;
    int pulse_cnt = 0;

    logic [3:0] tbl [8] = '{4'b0100, 4'b0101, 4'b0001, 4'b1001,
                            4'b1000, 4'b1010, 4'b0010, 4'b0110};

    stepper_phase_decoder dut (
        .CLK50MHZ     (clk),
        .RESETN       (rst_n),
        .phase_in     (phase_in),
        .pos_clr      (pos_clr),
        .err_clr      (err_clr),
        .step_pulse   (step_pulse),
        .dir          (dir),
        .locked       (locked),
        .position     (position),
        .err_illegal  (err_illegal),
        .err_skip     (err_skip),
        .period       (period),
        .period_valid (period_valid)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (step_pulse === 1'b1) pulse_cnt++;
    end

    task automatic drive(input logic [3:0] pat, input int n);
        phase_in = pat;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; phase_in = 4'b0000; pos_clr = 1'b0; err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({step_pulse, dir, locked, err_illegal, err_skip, period_valid} !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {step_pulse, dir, locked, err_illegal, err_skip, period_valid});
        end
        tests_run++;
        if (position !== 32'd0 || period !== 24'd0) begin
            tests_failed++;
            $display("FAIL reset_values: position=%0h period=%0h expected 0 0", position, period);
        end
        rst_n = 1'b1;
        drive(4'b0000, 2);
    endtask

    task automatic test_lock();
        pulse_cnt = 0;
        drive(tbl[0], LAT - 1);
        tests_run++;
        if (locked !== 1'b0) begin
            tests_failed++;
            $display("FAIL lock_early: locked=%b expected 0", locked);
        end
        drive(tbl[0], 1);
        tests_run++;
        if (locked !== 1'b1 || step_pulse !== 1'b0) begin
            tests_failed++;
            $display("FAIL lock_latency: locked=%b step=%b expected 1 0", locked, step_pulse);
        end
        drive(tbl[0], 50);
        tests_run++;
        if (pulse_cnt !== 0 || position !== 32'd0) begin
            tests_failed++;
            $display("FAIL lock_nostep: pulses=%0d position=%0d expected 0 0", pulse_cnt, position);
        end
    endtask

    task automatic test_forward();
        pulse_cnt = 0;
        drive(tbl[1], LAT - 1);
        tests_run++;
        if (step_pulse !== 1'b0) begin
            tests_failed++;
            $display("FAIL step_early: step=%b expected 0", step_pulse);
        end
        drive(tbl[1], 1);
        tests_run++;
        if (step_pulse !== 1'b1 || position !== 32'd1) begin
            tests_failed++;
            $display("FAIL step_latency: step=%b position=%0d expected 1 1", step_pulse, position);
        end
        drive(tbl[1], 100 - LAT);
        for (int i = 2; i <= 8; i++) drive(tbl[i % 8], 100);
        tests_run++;
        if (pulse_cnt !== 8 || dir !== 1'b0 || position !== 32'd8) begin
            tests_failed++;
            $display("FAIL fwd_cycle: pulses=%0d dir=%b position=%0d expected 8 0 8",
                     pulse_cnt, dir, position);
        end
    endtask

    task automatic test_reverse();
        pos_clr = 1'b1;
        drive(tbl[0], 1);
        pos_clr = 1'b0;
        tests_run++;
        if (position !== 32'd0) begin
            tests_failed++;
            $display("FAIL pos_clr: position=%0d expected 0", position);
        end
        pulse_cnt = 0;
        for (int r = 0; r < 3; r++)
            for (int k = 1; k <= 8; k++) drive(tbl[(8 - k) % 8], 100);
        tests_run++;
        if (pulse_cnt !== 24 || dir !== 1'b1 || position !== 32'hFFFF_FFE8) begin
            tests_failed++;
            $display("FAIL rev_cycle: pulses=%0d dir=%b position=%0h expected 24 1 ffffffe8",
                     pulse_cnt, dir, position);
        end
        pos_clr = 1'b1;
        drive(tbl[0], 1);
        pos_clr = 1'b0;
        drive(tbl[7], 100);
        tests_run++;
        if (position !== 32'hFFFF_FFFF) begin
            tests_failed++;
            $display("FAIL rev_wrap: position=%0h expected ffffffff", position);
        end
    endtask

    task automatic test_skip();
        drive(tbl[0], 100);
        pulse_cnt = 0;
        drive(tbl[2], 100);
        tests_run++;
        if (err_skip !== 1'b1 || pulse_cnt !== 0 || position !== 32'd0 || locked !== 1'b1) begin
            tests_failed++;
            $display("FAIL skip_detect: skip=%b pulses=%0d position=%0d locked=%b expected 1 0 0 1",
                     err_skip, pulse_cnt, position, locked);
        end
        drive(tbl[3], 100);
        tests_run++;
        if (pulse_cnt !== 1 || position !== 32'd1 || dir !== 1'b0) begin
            tests_failed++;
            $display("FAIL skip_reseed: pulses=%0d position=%0d dir=%b expected 1 1 0",
                     pulse_cnt, position, dir);
        end
        err_clr = 1'b1;
        drive(tbl[3], 1);
        err_clr = 1'b0;
        tests_run++;
        if (err_skip !== 1'b0) begin
            tests_failed++;
            $display("FAIL skip_clear: skip=%b expected 0", err_skip);
        end
    endtask

    task automatic test_illegal();
        drive(4'b1111, 100);
        tests_run++;
        if (err_illegal !== 1'b1 || locked !== 1'b0) begin
            tests_failed++;
            $display("FAIL illegal_detect: illegal=%b locked=%b expected 1 0", err_illegal, locked);
        end
        err_clr = 1'b1;
        drive(4'b1111, 1);
        err_clr = 1'b0;
        drive(4'b0000, 100);
        tests_run++;
        if (err_illegal !== 1'b0 || err_skip !== 1'b0 || locked !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_noerr: illegal=%b skip=%b locked=%b expected 0 0 0",
                     err_illegal, err_skip, locked);
        end
        pulse_cnt = 0;
        drive(tbl[1], 100);
        tests_run++;
        if (locked !== 1'b1 || pulse_cnt !== 0 || position !== 32'd1) begin
            tests_failed++;
            $display("FAIL relock: locked=%b pulses=%0d position=%0d expected 1 0 1",
                     locked, pulse_cnt, position);
        end
    endtask

    task automatic test_glitch();
        drive(tbl[0], 100);
        pulse_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            drive(tbl[1], 1);
            drive(tbl[0], 30);
        end
        drive(tbl[1], G - 6);
        drive(tbl[0], 40);
        tests_run++;
        if (pulse_cnt !== 0 || position !== 32'd0 || err_skip !== 1'b0 || locked !== 1'b1) begin
            tests_failed++;
            $display("FAIL glitch: pulses=%0d position=%0d skip=%b locked=%b expected 0 0 0 1",
                     pulse_cnt, position, err_skip, locked);
        end
        drive(tbl[1], 100);
        drive(tbl[2], LAT - 1);
        pos_clr = 1'b1;
        drive(tbl[2], 1);
        pos_clr = 1'b0;
        tests_run++;
        if (step_pulse !== 1'b1 || position !== 32'd0) begin
            tests_failed++;
            $display("FAIL clr_vs_step: step=%b position=%0d expected 1 0", step_pulse, position);
        end
        drive(tbl[2], 100 - LAT);
        drive(tbl[5], LAT - 1);
        err_clr = 1'b1;
        drive(tbl[5], 1);
        err_clr = 1'b0;
        tests_run++;
        if (err_skip !== 1'b1 || step_pulse !== 1'b0 || position !== 32'd0) begin
            tests_failed++;
            $display("FAIL errclr_vs_err: skip=%b step=%b position=%0d expected 1 0 0",
                     err_skip, step_pulse, position);
        end
        err_clr = 1'b1;
        drive(tbl[5], 1);
        err_clr = 1'b0;
        drive(tbl[5], 50);
    endtask

    task automatic test_rate();
`ifdef STEPPER_DEC_RATE_EN
        drive(tbl[6], LAT);
        tests_run++;
        if (step_pulse !== 1'b1 || period_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rate_first: step=%b pvalid=%b expected 1 0", step_pulse, period_valid);
        end
        drive(tbl[6], 500 - LAT);
        drive(tbl[7], LAT);
        tests_run++;
        if (period !== 24'd500 || period_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL rate_second: period=%0d pvalid=%b expected 500 1", period, period_valid);
        end
        drive(tbl[7], 500 - LAT);
        drive(4'b0000, 100);
        tests_run++;
        if (period !== 24'd500 || period_valid !== 1'b0 || locked !== 1'b0) begin
            tests_failed++;
            $display("FAIL rate_unlock: period=%0d pvalid=%b locked=%b expected 500 0 0",
                     period, period_valid, locked);
        end
`else
        drive(tbl[6], 100);
        drive(tbl[7], 100);
        tests_run++;
        if (period !== 24'd0 || period_valid !== 1'b0 || position !== 32'd2) begin
            tests_failed++;
            $display("FAIL rate_off: period=%0d pvalid=%b position=%0d expected 0 0 2",
                     period, period_valid, position);
        end
        drive(4'b0000, 100);
`endif
    endtask

    task automatic test_reset_mid();
        drive(tbl[0], 100);
        drive(tbl[1], 100);
        #5;
        rst_n = 1'b0;
        #2;
        tests_run++;
        if (locked !== 1'b0 || position !== 32'd0 || dir !== 1'b0 || err_skip !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid: locked=%b position=%0d dir=%b skip=%b expected 0 0 0 0",
                     locked, position, dir, err_skip);
        end
        drive(tbl[1], 2);
        rst_n = 1'b1;
        pulse_cnt = 0;
        drive(tbl[1], 100);
        tests_run++;
        if (locked !== 1'b1 || pulse_cnt !== 0 || position !== 32'd0) begin
            tests_failed++;
            $display("FAIL relock_after_reset: locked=%b pulses=%0d position=%0d expected 1 0 0",
                     locked, pulse_cnt, position);
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_forward();
        test_reverse();
        test_skip();
        test_illegal();
        test_glitch();
        test_rate();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
